// File: rtl/sd_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sd_cmd_sequencer
// Sends one 6-byte SD command frame (SPI mode) through a byte-wide SPI engine,
// then polls with 0xFF bytes until an R1 response (bit 7 clear) arrives or
// MAX_POLL poll bytes have been exchanged without one.
//
// Ports
//   clk          single clock, all state on posedge
//   reset        asynchronous, active-high reset
//   start        command request, accepted only while idle
//   cmd_idx      6-bit command index, latched on accepted start
//   cmd_arg      32-bit argument, latched on accepted start
//   busy         high while a command is in progress
//   resp_valid   one-cycle pulse when resp/timeout are valid
//   resp         R1 byte (0xFF on timeout), held until the next accepted start
//   timeout      no R1 within MAX_POLL polls, held until the next accepted start
//   spi_datain   byte to transmit in [7:0], [15:8] always zero
//   spi_en       one-cycle transfer-start pulse to the SPI byte engine
//   spi_dataout  received byte in [7:0], valid with spi_done
//   spi_done     one-cycle end-of-transfer pulse from the SPI byte engine
// -----------------------------------------------------------------------------
module sd_cmd_sequencer #(
   parameter int unsigned MAX_POLL = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  cmd_idx,
   input  logic [31:0] cmd_arg,
   output logic        busy,
   output logic        resp_valid,
   output logic [7:0]  resp,
   output logic        timeout,
   output logic [15:0] spi_datain,
   output logic        spi_en,
   input  logic [15:0] spi_dataout,
   input  logic        spi_done
);

   localparam int unsigned IDX_W      = 3;
   localparam int unsigned POLL_W     = 8;
   localparam int unsigned LAST_BYTE  = 5;
   localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(MAX_POLL);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LAST_BYTE);
   localparam logic [15:0]       POLL_WORD  = 16'h00FF;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SEND      = 3'd1,
      WAIT_SEND = 3'd2,
      POLL      = 3'd3,
      WAIT_POLL = 3'd4,
      FINISH    = 3'd5
   } state_t;

   state_t              state;
   logic [5:0]          idx_q;
   logic [31:0]         arg_q;
   logic [IDX_W-1:0]    byte_idx;
   logic [POLL_W-1:0]   poll_cnt;
   logic [POLL_W-1:0]   poll_cnt_inc_c;
   logic [IDX_W-1:0]    byte_idx_inc_c;
   logic [7:0]          next_byte_c;
   logic                unused_dataout_hi;

   // Only the low byte of the SPI engine return carries data.
   assign unused_dataout_hi = ^spi_dataout[15:8];

   // CRC-7 (x^7 + x^3 + 1), zero seed, MSB first over the first five frame bytes.
   function automatic logic [6:0] crc7_calc(input logic [39:0] data);
      logic [6:0] c;
      logic       fb;
      c = 7'h00;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ data[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   // Byte 'sel' of the command frame built from a latched index/argument.
   function automatic logic [7:0] frame_byte(input logic [5:0]       idx,
                                             input logic [31:0]      arg,
                                             input logic [IDX_W-1:0] sel);
      logic [7:0] b;
      case (sel)
         3'd0:    b = {2'b01, idx};
         3'd1:    b = arg[31:24];
         3'd2:    b = arg[23:16];
         3'd3:    b = arg[15:8];
         3'd4:    b = arg[7:0];
         default: b = {crc7_calc({2'b01, idx, arg}), 1'b1};
      endcase
      return b;
   endfunction

   // Next byte to send after the current one completes; uses latched values only.
   always_comb begin
      byte_idx_inc_c = IDX_W'(byte_idx + IDX_W'(1));
      poll_cnt_inc_c = POLL_W'(poll_cnt + POLL_W'(1));
      next_byte_c    = frame_byte(idx_q, arg_q, byte_idx_inc_c);
   end

   // Sequencer FSM. spi_en/spi_datain/resp_valid are registered on the transition
   // into SEND/POLL/FINISH so the pulse is visible for exactly the state's cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         resp       <= 8'h00;
         timeout    <= 1'b0;
         spi_datain <= 16'h0000;
         spi_en     <= 1'b0;
         idx_q      <= 6'd0;
         arg_q      <= 32'd0;
         byte_idx   <= '0;
         poll_cnt   <= '0;
      end else begin
         spi_en     <= 1'b0;
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx_q      <= cmd_idx;
                  arg_q      <= cmd_arg;
                  resp       <= 8'h00;
                  timeout    <= 1'b0;
                  byte_idx   <= '0;
                  poll_cnt   <= '0;
                  spi_datain <= {8'h00, 2'b01, cmd_idx};
                  spi_en     <= 1'b1;
                  busy       <= 1'b1;
                  state      <= SEND;
               end
            end

            SEND: state <= WAIT_SEND;

            WAIT_SEND: begin
               if (spi_done) begin
                  if (byte_idx < LAST_IDX) begin
                     byte_idx   <= byte_idx_inc_c;
                     spi_datain <= {8'h00, next_byte_c};
                     spi_en     <= 1'b1;
                     state      <= SEND;
                  end else begin
                     poll_cnt   <= '0;
                     spi_datain <= POLL_WORD;
                     spi_en     <= 1'b1;
                     state      <= POLL;
                  end
               end
            end

            POLL: state <= WAIT_POLL;

            WAIT_POLL: begin
               if (spi_done) begin
                  if (!spi_dataout[7]) begin
                     resp       <= spi_dataout[7:0];
                     resp_valid <= 1'b1;
                     state      <= FINISH;
                  end else if (poll_cnt_inc_c == POLL_LIMIT) begin
                     poll_cnt   <= poll_cnt_inc_c;
                     timeout    <= 1'b1;
                     resp       <= 8'hFF;
                     resp_valid <= 1'b1;
                     state      <= FINISH;
                  end else begin
                     poll_cnt   <= poll_cnt_inc_c;
                     spi_datain <= POLL_WORD;
                     spi_en     <= 1'b1;
                     state      <= POLL;
                  end
               end
            end

            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_sequencer
// Directed bench for sd_cmd_sequencer with a behavioural SPI byte engine that
// records transmitted bytes and answers polls from a per-test response table.
// -----------------------------------------------------------------------------
module tb_sd_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  cmd_idx;
   logic [31:0] cmd_arg;
   logic        busy;
   logic        resp_valid;
   logic [7:0]  resp;
   logic        timeout;
   logic [15:0] spi_datain;
   logic        spi_en;
   logic [15:0] spi_dataout;
   logic        spi_done;

   // Engine model state
   logic        resp_done = 1'b0;
   logic [15:0] resp_data = 16'h0000;
   logic        inj_done  = 1'b0;
   logic [7:0]  sent_q [$];
   logic [7:0]  poll_resp [16];
   logic [7:0]  exp_frame [6];
   int          xfer_cnt  = 0;
   int          en_count  = 0;
   int          rv_count  = 0;
   int          viol      = 0;
   bit          pending   = 1'b0;
   int          wait_cnt  = 0;
   int          pend_poll = 0;
   logic        prev_en   = 1'b0;

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  got_resp;
   logic        got_to;

   assign spi_done    = resp_done | inj_done;
   assign spi_dataout = inj_done ? 16'h0001 : resp_data;

   always #5 clk = ~clk;

   sd_cmd_sequencer #(.MAX_POLL(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .cmd_idx     (cmd_idx),
      .cmd_arg     (cmd_arg),
      .busy        (busy),
      .resp_valid  (resp_valid),
      .resp        (resp),
      .timeout     (timeout),
      .spi_datain  (spi_datain),
      .spi_en      (spi_en),
      .spi_dataout (spi_dataout),
      .spi_done    (spi_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // SPI byte engine: done three cycles after each spi_en; also flags protocol
   // violations (spi_en while outstanding, stretched pulse, nonzero high byte).
   always @(negedge clk) begin
      resp_done = 1'b0;
      if (resp_valid) rv_count++;
      if (spi_en && prev_en) viol++;
      if (spi_en && spi_datain[15:8] != 8'h00) viol++;
      prev_en = spi_en;
      if (pending) begin
         if (spi_en) viol++;
         if (wait_cnt == 0) begin
            if (pend_poll >= 0 && pend_poll < 16)
               resp_data = {8'h00, poll_resp[pend_poll[3:0]]};
            else
               resp_data = 16'h00FF;
            resp_done = 1'b1;
            pending   = 1'b0;
         end else begin
            wait_cnt--;
         end
      end else if (spi_en) begin
         sent_q.push_back(spi_datain[7:0]);
         en_count++;
         pend_poll = xfer_cnt - 6;
         xfer_cnt++;
         pending  = 1'b1;
         wait_cnt = 2;
      end
   end

   task automatic set_polls(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      for (int i = 0; i < 16; i++) poll_resp[i] = 8'hFF;
      poll_resp[0] = a;
      poll_resp[1] = b;
      poll_resp[2] = c;
   endtask

   // Issue one command and wait (bounded) for its resp_valid pulse.
   task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input bit dup_start);
      int  rv_before;
      bit  seen;
      sent_q.delete();
      xfer_cnt  = 0;
      rv_before = rv_count;
      @(negedge clk);
      start   = 1'b1;
      cmd_idx = idx;
      cmd_arg = arg;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      check({tag, "_en_first"}, 32'(spi_en), 32'd1);
      check({tag, "_resp_clr"}, 32'(resp), 32'h00);
      check({tag, "_to_clr"}, 32'(timeout), 32'd0);
      if (dup_start) begin
         cmd_idx = 6'd55;
         cmd_arg = 32'hDEADBEEF;
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      seen = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_rv_seen"}, 32'(seen), 32'd1);
      got_resp = resp;
      got_to   = timeout;
      @(negedge clk);
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      check({tag, "_rv_pulses"}, 32'(rv_count - rv_before), 32'd1);
   endtask

   task automatic check_frame(input string tag, input int polls);
      check({tag, "_xfers"}, 32'(sent_q.size()), 32'(6 + polls));
      for (int i = 0; i < 6; i++)
         if (i < sent_q.size())
            check($sformatf("%s_byte%0d", tag, i), 32'(sent_q[i]), 32'(exp_frame[i]));
      for (int i = 6; i < sent_q.size(); i++)
         check($sformatf("%s_poll%0d", tag, i - 6), 32'(sent_q[i]), 32'hFF);
   endtask

   initial begin
      int en_before;
      int rv_before;
      reset   = 1'b1;
      start   = 1'b0;
      cmd_idx = 6'd0;
      cmd_arg = 32'd0;
      set_polls(8'hFF, 8'hFF, 8'hFF);
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rv", 32'(resp_valid), 32'd0);
      check("rst_resp", 32'(resp), 32'h00);
      check("rst_to", 32'(timeout), 32'd0);
      check("rst_en", 32'(spi_en), 32'd0);
      check("rst_din", 32'(spi_datain), 32'h0000);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // CMD0, R1 0x01 on first poll
      set_polls(8'h01, 8'hFF, 8'hFF);
      exp_frame = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
      run_cmd("cmd0", 6'd0, 32'h0, 1'b0);
      check_frame("cmd0", 1);
      check("cmd0_resp", 32'(got_resp), 32'h01);
      check("cmd0_to", 32'(got_to), 32'd0);

      // Stray spi_done while idle
      en_before = en_count;
      rv_before = rv_count;
      @(negedge clk);
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("idle_done_en", 32'(en_count - en_before), 32'd0);
      check("idle_done_rv", 32'(rv_count - rv_before), 32'd0);
      check("idle_done_busy", 32'(busy), 32'd0);
      check("idle_done_resp", 32'(resp), 32'h01);

      // CMD8 with two busy polls before R1
      set_polls(8'hFF, 8'hFF, 8'h01);
      exp_frame = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
      run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b0);
      check_frame("cmd8", 3);
      check("cmd8_resp", 32'(got_resp), 32'h01);
      check("cmd8_to", 32'(got_to), 32'd0);

      // CMD55, card never answers: timeout after exactly MAX_POLL polls
      set_polls(8'hFF, 8'hFF, 8'hFF);
      exp_frame = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65};
      run_cmd("cmd55", 6'd55, 32'h0, 1'b0);
      check_frame("cmd55", 8);
      check("cmd55_resp", 32'(got_resp), 32'hFF);
      check("cmd55_to", 32'(got_to), 32'd1);
      check("cmd55_resp_hold", 32'(resp), 32'hFF);
      check("cmd55_to_hold", 32'(timeout), 32'd1);

      // Start re-pulsed mid-frame with different command must be ignored
      set_polls(8'hFF, 8'h00, 8'hFF);
      exp_frame = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
      run_cmd("dup", 6'd0, 32'h0, 1'b1);
      check_frame("dup", 2);
      check("dup_resp", 32'(got_resp), 32'h00);
      check("dup_to", 32'(got_to), 32'd0);

      // Reset while waiting for byte 2 to complete
      sent_q.delete();
      xfer_cnt = 0;
      set_polls(8'hFF, 8'hFF, 8'hFF);
      @(negedge clk);
      start   = 1'b1;
      cmd_idx = 6'd8;
      cmd_arg = 32'h0000_01AA;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && sent_q.size() < 3; c++) @(negedge clk);
      check("rstmid_bytes", 32'(sent_q.size()), 32'd3);
      @(negedge clk);
      check("rstmid_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_en", 32'(spi_en), 32'd0);
      check("rstmid_din", 32'(spi_datain), 32'h0000);
      check("rstmid_resp", 32'(resp), 32'h00);
      check("rstmid_to", 32'(timeout), 32'd0);
      check("rstmid_rv", 32'(resp_valid), 32'd0);
      repeat (6) @(negedge clk);
      reset = 1'b0;
      en_before = en_count;
      repeat (4) @(negedge clk);
      #1;
      check("rstmid_quiet", 32'(en_count - en_before), 32'd0);
      set_polls(8'h01, 8'hFF, 8'hFF);
      exp_frame = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65};
      run_cmd("after_rst", 6'd55, 32'h0, 1'b0);
      check_frame("after_rst", 1);
      check("after_rst_resp", 32'(got_resp), 32'h01);
      check("after_rst_to", 32'(got_to), 32'd0);

      check("protocol_viol", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
